// File: rtl/m2_clock_pkg.sv
// m2_clock_pkg: shared state encoding, reset defaults and config validation for the M2 generator.
package m2_clock_pkg;

    typedef enum logic [1:0] {STOPPED, LOW, HIGH} state_t;

    localparam int DEFAULT_PERIOD = 24;
    localparam int DEFAULT_HIGH   = 15;

    // high >= 1 and high < period together keep period-high non-zero and underflow-free
    function automatic logic cfg_valid(input int unsigned period, input int unsigned high);
        return high >= 1 && period >= 2 && high < period;
    endfunction

endpackage

// File: rtl/m2_clock_generator.sv
// m2_clock_generator: programmable, glitch-free cartridge M2 clock with run/stop, single-step and diagnostics.
module m2_clock_generator #(
    parameter int CNT_WIDTH       = 8,
    parameter int DEFAULT_PERIOD  = m2_clock_pkg::DEFAULT_PERIOD,
    parameter int DEFAULT_HIGH    = m2_clock_pkg::DEFAULT_HIGH,
    parameter int CYCLE_CNT_WIDTH = 16
) (
    input  logic                       master_clock,
    input  logic                       nreset,
    input  logic                       run,
    input  logic                       step,
    input  logic                       cfg_load,
    input  logic [CNT_WIDTH-1:0]       cfg_period,
    input  logic [CNT_WIDTH-1:0]       cfg_high,
    output logic                       m2,
    output logic                       m2_rise,
    output logic                       m2_fall,
    output logic                       running,
    output logic                       cfg_error,
    output logic [CYCLE_CNT_WIDTH-1:0] cycle_count
);
    import m2_clock_pkg::*;

    state_t               state, state_n;
    logic [CNT_WIDTH-1:0] phase_cnt, phase_n;
    logic [CNT_WIDTH-1:0] act_high, act_high_n;
    logic [CNT_WIDTH-1:0] shd_period, shd_high, shd_low;
    logic                 step_pending, pend_n;
    logic                 cfg_ok, boundary, falling;

    assign shd_low  = shd_period - shd_high;
    assign cfg_ok   = cfg_valid(32'(cfg_period), 32'(cfg_high));
    assign running  = state != STOPPED;
    assign falling  = state == HIGH && state_n != HIGH;
    // shadow config becomes active only when a new LOW phase is entered
    assign boundary = state_n == LOW && (state == STOPPED || state == HIGH);

    always_comb begin
        state_n    = state;
        phase_n    = phase_cnt;
        pend_n     = step_pending;
        act_high_n = boundary ? shd_high : act_high;
        if (step && !run && state != HIGH)
            pend_n = 1'b1;
        unique case (state)
            STOPPED: begin
                if (run || step_pending) begin
                    state_n = LOW;
                    phase_n = shd_low - 1'b1;
                end
            end
            LOW: begin
                if (!run && !step_pending)
                    state_n = STOPPED;
                else if (phase_cnt == '0) begin
                    state_n = HIGH;
                    phase_n = act_high - 1'b1;
                    pend_n  = 1'b0;
                end else
                    phase_n = phase_cnt - 1'b1;
            end
            HIGH: begin
                if (phase_cnt != '0)
                    phase_n = phase_cnt - 1'b1;
                else if (run) begin
                    state_n = LOW;
                    phase_n = shd_low - 1'b1;
                end else
                    state_n = STOPPED;
            end
            default: state_n = STOPPED;
        endcase
    end

    always_ff @(posedge master_clock or negedge nreset) begin
        if (!nreset) begin
            state        <= STOPPED;
            phase_cnt    <= '0;
            step_pending <= 1'b0;
            act_high     <= CNT_WIDTH'(DEFAULT_HIGH);
            shd_period   <= CNT_WIDTH'(DEFAULT_PERIOD);
            shd_high     <= CNT_WIDTH'(DEFAULT_HIGH);
            m2           <= 1'b0;
            m2_rise      <= 1'b0;
            m2_fall      <= 1'b0;
            cfg_error    <= 1'b0;
            cycle_count  <= '0;
        end else begin
            state        <= state_n;
            phase_cnt    <= phase_n;
            step_pending <= pend_n;
            act_high     <= act_high_n;
            m2           <= state_n == HIGH;
            m2_rise      <= state != HIGH && state_n == HIGH;
            m2_fall      <= falling;
            cfg_error    <= cfg_load && !cfg_ok;
            cycle_count  <= cycle_count + CYCLE_CNT_WIDTH'(falling);
            if (cfg_load && cfg_ok) begin
                shd_period <= cfg_period;
                shd_high   <= cfg_high;
            end
        end
    end

endmodule
